// File: rtl/btn_cmd_filter.sv
// rtl/btn_cmd_filter.sv - four-button synchronizer, debouncer and single-owner command FSM
// Optional auto-repeat of cmd_pulse while a button is held: define BTN_AUTOREPEAT_EN.
module btn_cmd_filter #(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int REPEAT_DELAY    = 2**24,
  parameter int REPEAT_PERIOD   = 2**22
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  output logic [3:0] cmd,
  output logic [3:0] cmd_pulse,
  output logic       conflict
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 2**20 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
  begin : g_bad_params
    $error("btn_cmd_filter: parameter out of legal range");
  end

  typedef enum logic [1:0] {IDLE, HELD, LOCKOUT} state_t;

  state_t        state, state_nx;
  logic [3:0]    sync1, sync2, stable;
  logic [CW-1:0] db_cnt [4];
  logic [3:0]    owner, owner_nx;
  logic [3:0]    cmd_nx, pulse_nx;
  logic          conflict_nx;
  logic          stable_onehot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Any cycle where synced agrees with the accepted level restarts that bit's count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign stable_onehot = (stable != 4'b0000) && ((stable & (stable - 4'd1)) == 4'b0000);

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0] rpt_cnt, rpt_cnt_nx;
  logic          rpt_first, rpt_first_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b0;
    end else begin
      rpt_cnt   <= rpt_cnt_nx;
      rpt_first <= rpt_first_nx;
    end
  end
`endif

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    pulse_nx = 4'b0000;
`ifdef BTN_AUTOREPEAT_EN
    rpt_cnt_nx   = rpt_cnt;
    rpt_first_nx = rpt_first;
`endif
    case (state)
      IDLE: begin
        if (stable_onehot) begin
          state_nx = HELD;
          owner_nx = stable;
          pulse_nx = stable;
`ifdef BTN_AUTOREPEAT_EN
          rpt_cnt_nx   = '0;
          rpt_first_nx = 1'b1;
`endif
        end else if (stable != 4'b0000) begin
          state_nx = LOCKOUT;
        end
      end
      HELD: begin
        if ((stable & owner) == 4'b0000) begin
          state_nx = (stable == 4'b0000) ? IDLE : LOCKOUT;
          owner_nx = 4'b0000;
        end else begin
`ifdef BTN_AUTOREPEAT_EN
          // rpt_cnt counts cycles since the last strobe (initial or repeat).
          if ((rpt_first && rpt_cnt == RW'(REPEAT_DELAY - 1)) ||
              (!rpt_first && rpt_cnt == RW'(REPEAT_PERIOD - 1))) begin
            pulse_nx     = owner;
            rpt_cnt_nx   = '0;
            rpt_first_nx = 1'b0;
          end else begin
            rpt_cnt_nx = rpt_cnt + RW'(1);
          end
`endif
        end
      end
      LOCKOUT: begin
        if (stable == 4'b0000) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        owner_nx = 4'b0000;
      end
    endcase
    cmd_nx      = (state_nx == HELD) ? owner_nx : 4'b0000;
    conflict_nx = (state_nx == LOCKOUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      cmd       <= '0;
      cmd_pulse <= '0;
      conflict  <= 1'b0;
    end else begin
      state     <= state_nx;
      owner     <= owner_nx;
      cmd       <= cmd_nx;
      cmd_pulse <= pulse_nx;
      conflict  <= conflict_nx;
    end
  end

endmodule

// File: tb/tb_btn_cmd_filter.sv
// tb/tb_btn_cmd_filter.sv - directed bench for btn_cmd_filter with a cmd_pulse scoreboard
module tb_btn_cmd_filter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_raw = 4'b0000;
  logic [3:0] cmd, cmd_pulse;
  logic       conflict;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  btn_cmd_filter #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .cmd(cmd),
    .cmd_pulse(cmd_pulse),
    .conflict(conflict)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b cycle=%0d", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp_v);
    total++;
    assert (obs == exp_v)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic push_pulse(input int c, input logic [3:0] v);
    exp_t x;
    x.cyc = c;
    x.val = v;
    sb.push_back(x);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (cmd_pulse !== 4'b0000) begin
      total++;
      assert (sb.size() != 0)
      else begin
        bad++;
        $error("FAIL pulse_unexpected observed=%b expected=none cycle=%0d", cmd_pulse, cyc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_int("pulse_cycle", cyc, e.cyc);
        check4("pulse_val", cmd_pulse, e.val);
      end
    end
  end

  initial begin
    // reset state
    wait_cyc(2);
    check4("rst_cmd", cmd, 4'b0000);
    check4("rst_pulse", cmd_pulse, 4'b0000);
    check4("rst_conflict", {3'b000, conflict}, 4'b0000);
    rst_n = 1'b1;
    wait_cyc(3);

    // single press: accept at edge 7, release clears at edge 7
    btn_raw = 4'b0010; t0 = cyc; push_pulse(t0 + 7, 4'b0010);
    wait_cyc(6); check4("press_early", cmd, 4'b0000);
    wait_cyc(1); check4("press_edge7", cmd, 4'b0010);
    wait_cyc(5); check4("press_hold", cmd, 4'b0010);
    btn_raw = 4'b0000;
    wait_cyc(6); check4("release_early", cmd, 4'b0010);
    wait_cyc(1); check4("release_edge7", cmd, 4'b0000);
    wait_cyc(3);

    // bounce shorter than the debounce window never registers
    for (int i = 0; i < 40; i++) begin
      btn_raw[0] = (i % 4) < 2;
      wait_cyc(1);
      check4("bounce_cmd", cmd, 4'b0000);
    end
    btn_raw = 4'b0000;
    wait_cyc(10); check4("bounce_after", cmd, 4'b0000);

    // simultaneous two-button press -> lockout until all released
    btn_raw = 4'b0101;
    wait_cyc(6); check4("lock_early", {3'b000, conflict}, 4'b0000);
    wait_cyc(1); check4("lock_conflict", {3'b000, conflict}, 4'b0001);
    check4("lock_cmd", cmd, 4'b0000);
    btn_raw = 4'b0100;
    wait_cyc(10); check4("lock_partial", {3'b000, conflict}, 4'b0001);
    check4("lock_partial_cmd", cmd, 4'b0000);
    btn_raw = 4'b0000;
    wait_cyc(6); check4("lock_rel_early", {3'b000, conflict}, 4'b0001);
    wait_cyc(1); check4("lock_exit", {3'b000, conflict}, 4'b0000);
    wait_cyc(3);

    // owner keeps HELD against a second button; owner release -> lockout
    btn_raw = 4'b0001; t0 = cyc; push_pulse(t0 + 7, 4'b0001);
    wait_cyc(8); check4("own_held", cmd, 4'b0001);
    btn_raw = 4'b1001;
    wait_cyc(10); check4("own_ignore", cmd, 4'b0001);
    check4("own_noconf", {3'b000, conflict}, 4'b0000);
    btn_raw = 4'b1000;
    wait_cyc(7); check4("own_lock", {3'b000, conflict}, 4'b0001);
    check4("own_lock_cmd", cmd, 4'b0000);
    btn_raw = 4'b0000;
    wait_cyc(7); check4("own_idle", {3'b000, conflict}, 4'b0000);
    wait_cyc(3);

    // async reset while HELD, button held through reset release
    btn_raw = 4'b0010; t0 = cyc; push_pulse(t0 + 7, 4'b0010);
    wait_cyc(9); check4("pre_rst_cmd", cmd, 4'b0010);
    #2 rst_n = 1'b0;
    #1 check4("async_rst_cmd", cmd, 4'b0000);
    wait_cyc(2);
    rst_n = 1'b1; t0 = cyc; push_pulse(t0 + 7, 4'b0010);
    wait_cyc(6); check4("post_rst_early", cmd, 4'b0000);
    wait_cyc(1); check4("post_rst_edge7", cmd, 4'b0010);
    btn_raw = 4'b0000;
    wait_cyc(10);

    // long hold: repeat strobes only with auto-repeat built in
    btn_raw = 4'b0100; t0 = cyc; push_pulse(t0 + 7, 4'b0100);
`ifdef BTN_AUTOREPEAT_EN
    for (int k = 10; k <= 35; k += 5) push_pulse(t0 + 7 + k, 4'b0100);
`endif
    wait_cyc(40);
    btn_raw = 4'b0000;
    wait_cyc(6); check4("rpt_hold", cmd, 4'b0100);
    wait_cyc(1); check4("rpt_release", cmd, 4'b0000);
    wait_cyc(10);

    check_int("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
